// File: rtl/typing_checker.sv
// ---------------------------------------------------------------------------
// typing_checker
//
// Core of the typing game. It fetches target words from an external word
// store, compares each key press with the current target character, writes
// matched characters to the LCD driver and counts hits and misses. When
// STRICT is set, a miss sends the player back to the start of the word and
// clears the LCD line. When STRICT is clear, a miss is only counted.
//
// Parameters
//   MAX_LEN   : maximum characters per word (>= 2)
//   NUM_WORDS : words per game (>= 1)
//   CNT_W     : width of the saturating hit/miss counters
//   STRICT    : 1 = a miss restarts the word, 0 = a miss is only counted
//
// Ports
//   clk, reset    : system clock and synchronous active-high reset
//   key_ascii     : ASCII code of the current/last key
//   key_released  : high while the last key event is a release
//   restart       : one-cycle pulse that starts a new game
//   word_req      : high while a word is being fetched
//   word_idx      : index of the requested/current word
//   word_data     : MAX_LEN bytes, char i at [8*i+:8], 0x00 terminates
//   word_ack      : word_data valid (sampled while word_req is high)
//   lcd_wen       : one-cycle LCD write strobe
//   lcd_pos       : LCD column for lcd_char
//   lcd_char      : character to write
//   lcd_clr       : one-cycle LCD line clear
//   char_idx      : index of the next expected character
//   hit_count     : correct presses (saturating)
//   miss_count    : wrong presses (saturating)
//   done          : game complete
// ---------------------------------------------------------------------------
module typing_checker #(
  parameter int   MAX_LEN   = 16,
  parameter int   NUM_WORDS = 16,
  parameter int   CNT_W     = 8,
  parameter bit   STRICT    = 1'b0,
  localparam int  IW        = (MAX_LEN   > 2) ? $clog2(MAX_LEN)   : 1,
  localparam int  WW        = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           key_ascii,
  input  logic                 key_released,
  input  logic                 restart,
  output logic                 word_req,
  output logic [WW-1:0]        word_idx,
  input  logic [8*MAX_LEN-1:0] word_data,
  input  logic                 word_ack,
  output logic                 lcd_wen,
  output logic [IW-1:0]        lcd_pos,
  output logic [7:0]           lcd_char,
  output logic                 lcd_clr,
  output logic [IW-1:0]        char_idx,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_TYPE  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state;
  logic                 rel_prev;
  logic [7:0]           ascii_prev;
  logic [8*MAX_LEN-1:0] target;

  logic                 press;
  logic [7:0]           cur_char;
  logic [7:0]           next_char;
  logic                 last_char;
  logic                 last_word;

  // -------------------------------------------------------------------------
  // Key event detection. A press is a non-release status that is either the
  // first after a release or a change of key while the key is held down.
  // This turns a held key into a single event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_prev   <= 1'b1;
      ascii_prev <= 8'h00;
    end else begin
      rel_prev   <= key_released;
      ascii_prev <= key_ascii;
    end
  end

  assign press = !key_released && (rel_prev || (key_ascii != ascii_prev));

  // -------------------------------------------------------------------------
  // Target word buffer. It is read only in ST_TYPE, and a fetch always fills
  // it before the state machine reaches ST_TYPE.
  // NOTE: wide data-only storage is left out of reset. Nothing observes it
  // before it is loaded, and keeping it out of reset keeps the reset net off
  // MAX_LEN*8 flops.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state == ST_FETCH) && word_ack && !restart) begin
      target <= word_data;
    end
  end

  assign cur_char = target[8*int'(char_idx) +: 8];

  // The look-ahead is guarded so that it never indexes past the last slot.
  // A full-length word has no terminator byte.
  // NOTE: every signal written in an always_comb gets a default value first.
  // A path that leaves it unassigned would infer a latch.
  always_comb begin
    next_char = 8'h00;
    if (int'(char_idx) < MAX_LEN - 1) begin
      next_char = target[8*(int'(char_idx) + 1) +: 8];
    end
  end

  assign last_char = (int'(char_idx) == MAX_LEN - 1) || (next_char == 8'h00);
  assign last_word = (int'(word_idx) == NUM_WORDS - 1);

  // Moore decodes of the state register.
  assign word_req = (state == ST_FETCH);
  assign done     = (state == ST_DONE);

  // -------------------------------------------------------------------------
  // Game state machine and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only. The pulse
  // outputs take a default of 0 at the top of the block, and a later
  // assignment in the same cycle overrides it. This works because the last
  // non-blocking update to a signal is the one that lands.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    lcd_wen <= 1'b0;
    lcd_clr <= 1'b0;

    if (reset) begin
      state      <= ST_FETCH;
      word_idx   <= '0;
      char_idx   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      lcd_pos    <= '0;
      lcd_char   <= 8'h00;
    end else if (restart) begin
      // Restart aborts the current word and drops any ack in this cycle.
      state      <= ST_FETCH;
      word_idx   <= '0;
      char_idx   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (word_ack) begin
            if (word_data[7:0] == 8'h00) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_TYPE;
              lcd_clr  <= 1'b1;
              char_idx <= '0;
            end
          end
        end

        ST_TYPE: begin
          if (press) begin
            if (key_ascii == cur_char) begin
              lcd_wen  <= 1'b1;
              lcd_pos  <= char_idx;
              lcd_char <= key_ascii;
              if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;

              if (last_char) begin
                char_idx <= '0;
                if (last_word) begin
                  state <= ST_DONE;
                end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= ST_FETCH;
                end
              end else begin
                char_idx <= char_idx + 1'b1;
              end
            end else begin
              if (miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
              if (STRICT) begin
                char_idx <= '0;
                lcd_clr  <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          // Only reset or restart leaves this state.
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_typing_checker.sv
// ---------------------------------------------------------------------------
// tb_typing_checker
//
// Runs two typing_checker instances side by side from the same keyboard
// stimulus. Index 0 uses lenient mode and index 1 uses strict mode. Each
// instance has its own word-store acknowledge. A behavioural game model per
// instance predicts all outputs, and these are compared every cycle on the
// falling edge. Directed scenarios pin the model with hand-computed values.
// A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_typing_checker;

  localparam int MAX_LEN   = 8;
  localparam int NUM_WORDS = 4;
  localparam int CNT_W     = 4;
  localparam int IW        = 3;
  localparam int WW        = 2;
  localparam int SAT       = (1 << CNT_W) - 1;

  localparam int P_FETCH = 0;
  localparam int P_TYPE  = 1;
  localparam int P_DONE  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset        = 1'b1;
  logic       restart      = 1'b0;
  logic       key_released = 1'b1;
  logic [7:0] key_ascii    = 8'h00;

  logic [1:0]                     word_ack;
  logic [1:0][8*MAX_LEN-1:0]      word_data;
  logic [1:0]                     word_req;
  logic [1:0][WW-1:0]             word_idx;
  logic [1:0]                     lcd_wen;
  logic [1:0][IW-1:0]             lcd_pos;
  logic [1:0][7:0]                lcd_char;
  logic [1:0]                     lcd_clr;
  logic [1:0][IW-1:0]             char_idx;
  logic [1:0][CNT_W-1:0]          hit_count;
  logic [1:0][CNT_W-1:0]          miss_count;
  logic [1:0]                     done;

  typing_checker #(.MAX_LEN(MAX_LEN), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W), .STRICT(1'b0)) u_lenient (
    .clk(clk), .reset(reset), .key_ascii(key_ascii), .key_released(key_released),
    .restart(restart), .word_req(word_req[0]), .word_idx(word_idx[0]),
    .word_data(word_data[0]), .word_ack(word_ack[0]), .lcd_wen(lcd_wen[0]),
    .lcd_pos(lcd_pos[0]), .lcd_char(lcd_char[0]), .lcd_clr(lcd_clr[0]),
    .char_idx(char_idx[0]), .hit_count(hit_count[0]), .miss_count(miss_count[0]),
    .done(done[0])
  );

  typing_checker #(.MAX_LEN(MAX_LEN), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W), .STRICT(1'b1)) u_strict (
    .clk(clk), .reset(reset), .key_ascii(key_ascii), .key_released(key_released),
    .restart(restart), .word_req(word_req[1]), .word_idx(word_idx[1]),
    .word_data(word_data[1]), .word_ack(word_ack[1]), .lcd_wen(lcd_wen[1]),
    .lcd_pos(lcd_pos[1]), .lcd_char(lcd_char[1]), .lcd_clr(lcd_clr[1]),
    .char_idx(char_idx[1]), .hit_count(hit_count[1]), .miss_count(miss_count[1]),
    .done(done[1])
  );

  // Word store: it answers whatever address each DUT presents.
  logic [7:0] words [NUM_WORDS][MAX_LEN];

  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < MAX_LEN; i++)
        word_data[d][8*i +: 8] = words[word_idx[d]][i];
  end

  // ---------------------------------------------------------------- model --
  int         m_phase [2];
  int         m_widx  [2];
  int         m_cidx  [2];
  int         m_hits  [2];
  int         m_miss  [2];
  int         m_pos   [2];
  int         m_char  [2];
  bit         m_wen   [2];
  bit         m_clr   [2];
  logic [7:0] m_tgt   [2][MAX_LEN];
  logic [7:0] prev_key;
  bit         prev_rel;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;
  int ack_mode = 0;  // 0: ack when fetching, 1: random, 2: never, 3: always
  int clr_cnt [2];
  int wlog0 [$];
  int wlog1 [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, got, exp);
    end
  endtask

  task automatic model_step(input int d, input bit pr);
    bit last;
    m_wen[d] = 1'b0;
    m_clr[d] = 1'b0;
    if (reset) begin
      m_phase[d] = P_FETCH; m_widx[d] = 0; m_cidx[d] = 0;
      m_hits[d] = 0; m_miss[d] = 0; m_pos[d] = 0; m_char[d] = 0;
    end else if (restart) begin
      m_phase[d] = P_FETCH; m_widx[d] = 0; m_cidx[d] = 0;
      m_hits[d] = 0; m_miss[d] = 0;
    end else if (m_phase[d] == P_FETCH) begin
      if (word_ack[d]) begin
        for (int i = 0; i < MAX_LEN; i++) m_tgt[d][i] = words[m_widx[d]][i];
        if (m_tgt[d][0] == 8'h00) begin
          m_phase[d] = P_DONE;
        end else begin
          m_phase[d] = P_TYPE; m_clr[d] = 1'b1; m_cidx[d] = 0;
        end
      end
    end else if (m_phase[d] == P_TYPE && pr) begin
      if (key_ascii == m_tgt[d][m_cidx[d]]) begin
        m_wen[d] = 1'b1; m_pos[d] = m_cidx[d]; m_char[d] = key_ascii;
        if (m_hits[d] < SAT) m_hits[d]++;
        if (m_cidx[d] == MAX_LEN - 1) last = 1'b1;
        else last = (m_tgt[d][m_cidx[d] + 1] == 8'h00);
        if (last) begin
          m_cidx[d] = 0;
          if (m_widx[d] == NUM_WORDS - 1) m_phase[d] = P_DONE;
          else begin m_widx[d]++; m_phase[d] = P_FETCH; end
        end else begin
          m_cidx[d]++;
        end
      end else begin
        if (m_miss[d] < SAT) m_miss[d]++;
        if (d == 1) begin m_cidx[d] = 0; m_clr[d] = 1'b1; end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d word_req", d),   word_req[d],   (m_phase[d] == P_FETCH));
      check($sformatf("d%0d done", d),       done[d],       (m_phase[d] == P_DONE));
      check($sformatf("d%0d word_idx", d),   word_idx[d],   m_widx[d]);
      check($sformatf("d%0d hit_count", d),  hit_count[d],  m_hits[d]);
      check($sformatf("d%0d miss_count", d), miss_count[d], m_miss[d]);
      check($sformatf("d%0d lcd_wen", d),    lcd_wen[d],    m_wen[d]);
      check($sformatf("d%0d lcd_clr", d),    lcd_clr[d],    m_clr[d]);
      check($sformatf("d%0d lcd_pos", d),    lcd_pos[d],    m_pos[d]);
      check($sformatf("d%0d lcd_char", d),   lcd_char[d],   m_char[d]);
      if (m_phase[d] == P_TYPE)
        check($sformatf("d%0d char_idx", d), char_idx[d],   m_cidx[d]);
    end
  endtask

  // One clock cycle: inputs are already set, so choose acks, step the models
  // on the rising edge, and compare and log on the falling edge.
  task automatic tick();
    bit pr;
    for (int d = 0; d < 2; d++) begin
      case (ack_mode)
        0:       word_ack[d] = (m_phase[d] == P_FETCH);
        1:       word_ack[d] = ($urandom_range(0, 2) == 0);
        2:       word_ack[d] = 1'b0;
        default: word_ack[d] = 1'b1;
      endcase
    end
    @(posedge clk);
    pr = !key_released && (prev_rel || key_ascii != prev_key);
    model_step(0, pr);
    model_step(1, pr);
    if (reset) begin prev_rel = 1'b1; prev_key = 8'h00; end
    else begin prev_rel = key_released; prev_key = key_ascii; end
    @(negedge clk);
    cycle++;
    compare_all();
    if (lcd_wen[0] === 1'b1) wlog0.push_back(int'(lcd_pos[0]) * 256 + int'(lcd_char[0]));
    if (lcd_wen[1] === 1'b1) wlog1.push_back(int'(lcd_pos[1]) * 256 + int'(lcd_char[1]));
    for (int d = 0; d < 2; d++) if (lcd_clr[d] === 1'b1) clr_cnt[d]++;
  endtask

  task automatic idle(input int n);
    key_released = 1'b1;
    repeat (n) tick();
  endtask

  task automatic press_key(input logic [7:0] ch, input int hold);
    key_ascii = ch; key_released = 1'b0;
    repeat (hold) tick();
    key_released = 1'b1;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; key_released = 1'b1; key_ascii = 8'h00; ack_mode = 0;
    repeat (2) tick();
    reset = 1'b0;
    wlog0.delete(); wlog1.delete();
    clr_cnt[0] = 0; clr_cnt[1] = 0;
  endtask

  task automatic set_word(input int w, input string s);
    for (int i = 0; i < MAX_LEN; i++)
      words[w][i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  function automatic int wentry(input int d, input int k);
    if (d == 0) return (k < wlog0.size()) ? wlog0[k] : -1;
    return (k < wlog1.size()) ? wlog1[k] : -1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = P_FETCH; m_widx[d] = 0; m_cidx[d] = 0; m_hits[d] = 0;
      m_miss[d] = 0; m_pos[d] = 0; m_char[d] = 0; m_wen[d] = 0; m_clr[d] = 0;
      clr_cnt[d] = 0;
      for (int i = 0; i < MAX_LEN; i++) m_tgt[d][i] = 8'h00;
    end
    prev_rel = 1'b1; prev_key = 8'h00;
    word_ack = 2'b00;
    for (int w = 0; w < NUM_WORDS; w++) set_word(w, "");

    // Two-word game "abc", "d". The empty third word ends the game.
    set_word(0, "abc"); set_word(1, "d");
    do_reset();
    check("reset word_req", word_req[0], 1);
    check("reset hit_count", hit_count[0], 0);
    check("reset lcd_char", lcd_char[1], 0);
    idle(3);
    press_key("a", 2); press_key("b", 2); press_key("c", 2); press_key("d", 2);
    idle(2);
    check("abcd write0", wentry(0, 0), 32'h0061);
    check("abcd write1", wentry(0, 1), 32'h0162);
    check("abcd write2", wentry(0, 2), 32'h0263);
    check("abcd write3", wentry(0, 3), 32'h0064);
    check("abcd nwrites", wlog0.size(), 4);
    check("abcd clr pulses", clr_cnt[0], 2);
    check("abcd hits", hit_count[0], 4);
    check("abcd done", done[0], 1);
    check("abcd model hits", m_hits[1], 4);

    // Mode difference: a, x, a on "abc".
    set_word(0, "abc"); set_word(1, "");
    do_reset();
    idle(3);
    press_key("a", 1); press_key("x", 1); press_key("a", 1);
    check("axa lenient miss", miss_count[0], 2);
    check("axa lenient char_idx", char_idx[0], 1);
    check("axa lenient clr", clr_cnt[0], 1);
    check("axa lenient nwrites", wlog0.size(), 1);
    check("axa strict miss", miss_count[1], 1);
    check("axa strict char_idx", char_idx[1], 1);
    check("axa strict clr", clr_cnt[1], 2);
    check("axa strict write1", wentry(1, 1), 32'h0061);

    // Held key yields one event, and re-pressing after a release yields another.
    do_reset();
    idle(3);
    press_key("a", 50);
    check("hold nwrites", wlog0.size(), 1);
    press_key("b", 2);
    check("hold write1", wentry(0, 1), 32'h0162);

    // A full-length word has no terminator byte.
    set_word(0, "ABCDEFGH"); set_word(1, "z");
    do_reset();
    idle(3);
    for (int i = 0; i < MAX_LEN; i++) press_key(8'h41 + 8'(i), 1);
    check("full word_idx", word_idx[0], 1);
    check("full hits", hit_count[1], MAX_LEN);
    check("full last write", wentry(0, MAX_LEN - 1), 32'h0748);

    // Miss saturation, then a restart in the same cycle as word_ack.
    set_word(0, "abc"); set_word(1, "d");
    do_reset();
    idle(3);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) press_key("q", 1);
    check("sat lenient miss", miss_count[0], SAT);
    check("sat strict miss", miss_count[1], SAT);
    ack_mode = 2;
    press_key("a", 1); press_key("b", 1); press_key("c", 1);
    idle(2);
    check("pre-restart word_idx", word_idx[0], 1);
    ack_mode = 3; restart = 1'b1;
    tick();
    restart = 1'b0; ack_mode = 2;
    check("restart word_req", word_req[1], 1);
    check("restart word_idx", word_idx[1], 0);
    check("restart miss", miss_count[0], 0);
    check("restart hits", hit_count[1], 0);
    ack_mode = 0;
    idle(3);

    // Randomized play against the models.
    for (int w = 0; w < NUM_WORDS; w++) begin
      int len = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++)
        words[w][i] = (i < len) ? (8'h61 + 8'($urandom_range(0, 3))) : 8'h00;
    end
    if ($urandom_range(0, 1) == 1) set_word(NUM_WORDS - 1, "");
    do_reset();
    ack_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      key_released = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) key_ascii = m_tgt[0][m_cidx[0]];
        else key_ascii = 8'h61 + 8'($urandom_range(0, 3));
      end
      restart = ($urandom_range(0, 149) == 0);
      tick();
    end
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
